// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Used by regfile_mp and regfile_scoreboard.
package regfile_pkg;

    localparam int REG_ZERO  = 0;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;
    // Widest pending vector popcount accepts; callers zero-extend into it.
    localparam int MAX_DEPTH = 256;

    function automatic int unsigned popcount(input logic [MAX_DEPTH-1:0] bits);
        int unsigned n;
        n = 0;
        for (int k = 0; k < MAX_DEPTH; k++) begin
            n += int'(bits[k]);
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: issue sets a bit, writeback clears it.
// When both happen together, the set wins. Register 0 is never pending.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NWRITE = 1,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NWRITE-1:0]    we,
    input  logic [NWRITE*AW-1:0] wa,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_wa,
    output logic [DEPTH-1:0]     pending,
    output logic [AW:0]          pend_count
);

    logic [DEPTH-1:0]     pend_reg;
    logic [DEPTH-1:0]     pend_next;
    logic [AW:0]          count_reg;
    logic [AW:0]          count_next;
    logic [MAX_DEPTH-1:0] pend_ext;

    always_comb begin
        pend_next = pend_reg;
        for (int i = 0; i < NWRITE; i++) begin
            if (we[i]) begin
                pend_next[wa[i*AW +: AW]] = 1'b0;
            end
        end
        // Applied after the clears so a new producer supersedes the writeback.
        if (issue_valid) begin
            pend_next[issue_wa] = 1'b1;
        end
        pend_next[REG_ZERO] = 1'b0;

        pend_ext                = '0;
        pend_ext[DEPTH-1:0]     = pend_next;
        count_next              = (AW+1)'(popcount(pend_ext));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_reg  <= '0;
            count_reg <= '0;
        end else begin
            pend_reg  <= pend_next;
            count_reg <= count_next;
        end
    end

    assign pending    = pend_reg;
    assign pend_count = count_reg;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with combinational reads, synchronous writes and a
// pending scoreboard. Define REGFILE_BYPASS_EN to forward same-cycle write data.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NREAD  = 2,
    parameter int NWRITE = 1,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NWRITE-1:0]       we,
    input  logic [NWRITE*AW-1:0]    wa,
    input  logic [NWRITE*WIDTH-1:0] wd,
    input  logic [NREAD*AW-1:0]     ra,
    output logic [NREAD*WIDTH-1:0]  rd,
    output logic [NREAD-1:0]        rd_pending,
    input  logic                    issue_valid,
    input  logic [AW-1:0]           issue_wa,
    output logic [AW:0]             pend_count
);

    logic [WIDTH-1:0] rf_reg [DEPTH];
    logic [DEPTH-1:0] pending;

    // Ascending port order makes the highest-index port win on a collision.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                rf_reg[r] <= '0;
            end
        end else begin
            for (int i = 0; i < NWRITE; i++) begin
                if (we[i] && (wa[i*AW +: AW] != AW'(REG_ZERO))) begin
                    rf_reg[wa[i*AW +: AW]] <= wd[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    regfile_scoreboard #(
        .DEPTH  (DEPTH),
        .NWRITE (NWRITE),
        .AW     (AW)
    ) u_scoreboard (
        .clk         (clk),
        .reset_n     (reset_n),
        .we          (we),
        .wa          (wa),
        .issue_valid (issue_valid),
        .issue_wa    (issue_wa),
        .pending     (pending),
        .pend_count  (pend_count)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NREAD; gi++) begin : g_read
            logic [AW-1:0]    addr;
            logic [WIDTH-1:0] rd_word;
            logic             rd_pend;

            assign addr = ra[gi*AW +: AW];

            always_comb begin
                rd_word = rf_reg[addr];
                rd_pend = pending[addr];
                if (addr == AW'(REG_ZERO)) begin
                    rd_word = '0;
                    rd_pend = 1'b0;
                end
`ifdef REGFILE_BYPASS_EN
                for (int i = 0; i < NWRITE; i++) begin
                    if (we[i] && (wa[i*AW +: AW] == addr) && (addr != AW'(REG_ZERO))) begin
                        rd_word = wd[i*WIDTH +: WIDTH];
                        rd_pend = 1'b0;
                    end
                end
`endif
            end

            assign rd[gi*WIDTH +: WIDTH] = rd_word;
            assign rd_pending[gi]        = rd_pend;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (two read and two write ports).
module tb_regfile_mp;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 32;
    localparam int NREAD  = 2;
    localparam int NWRITE = 2;
    localparam int AW     = 5;

    logic                    clk;
    logic                    reset_n;
    logic [NWRITE-1:0]       we;
    logic [NWRITE*AW-1:0]    wa;
    logic [NWRITE*WIDTH-1:0] wd;
    logic [NREAD*AW-1:0]     ra;
    logic [NREAD*WIDTH-1:0]  rd;
    logic [NREAD-1:0]        rd_pending;
    logic                    issue_valid;
    logic [AW-1:0]           issue_wa;
    logic [AW:0]             pend_count;

    int compared   = 0;
    int mismatched = 0;

    regfile_mp #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .NREAD  (NREAD),
        .NWRITE (NWRITE)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .we          (we),
        .wa          (wa),
        .wd          (wd),
        .ra          (ra),
        .rd          (rd),
        .rd_pending  (rd_pending),
        .issue_valid (issue_valid),
        .issue_wa    (issue_wa),
        .pend_count  (pend_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance one rising edge, then move 1 ns past it before touching inputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we          = '0;
        wa          = '0;
        wd          = '0;
        issue_valid = 1'b0;
        issue_wa    = '0;
    endtask

    initial begin
        reset_n = 1'b0;
        ra      = '0;
        idle();

        // Reset
        tick();
        reset_n = 1'b1;
        #1;
        check("rst_count", 32'(pend_count), 32'd0);
        for (int a = 0; a < DEPTH; a++) begin
            ra = {5'(a), 5'(DEPTH - 1 - a)};
            #1;
            check("rst_rd0", rd[31:0], 32'h0);
            check("rst_rd1", rd[63:32], 32'h0);
            check("rst_pend", 32'(rd_pending), 32'h0);
        end

        // Write/read; same-cycle read shows old contents unless bypassing
        we = 2'b01; wa[4:0] = 5'd5; wd[31:0] = 32'hDEADBEEF; ra = {5'd0, 5'd5};
        #1;
`ifdef REGFILE_BYPASS_EN
        check("wr5_samecyc", rd[31:0], 32'hDEADBEEF);
`else
        check("wr5_samecyc", rd[31:0], 32'h0);
`endif
        tick();
        idle();
        #1;
        check("wr5_read", rd[31:0], 32'hDEADBEEF);

        // Write to register 0 is dropped
        we = 2'b01; wa[4:0] = 5'd0; wd[31:0] = 32'h1234;
        tick();
        idle();
        ra = {5'd5, 5'd0};
        #1;
        check("wr0_read", rd[31:0], 32'h0);
        check("wr5_port1", rd[63:32], 32'hDEADBEEF);

        // Two ports to one address: port 1 wins
        we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h22, 32'h11};
        tick();
        idle();
        ra = {5'd7, 5'd0};
        #1;
        check("conflict7", rd[63:32], 32'h22);

        // Scoreboard
        issue_valid = 1'b1; issue_wa = 5'd3;
        tick();
        issue_wa = 5'd9;
        tick();
        idle();
        ra = {5'd9, 5'd3};
        #1;
        check("sb_count2", 32'(pend_count), 32'd2);
        check("sb_pend3_9", 32'(rd_pending), 32'b11);

        issue_valid = 1'b1; issue_wa = 5'd3;
        tick();
        idle();
        #1;
        check("sb_reissue", 32'(pend_count), 32'd2);

        we = 2'b01; wa[4:0] = 5'd3; wd[31:0] = 32'h33;
        tick();
        idle();
        #1;
        check("sb_wb3_cnt", 32'(pend_count), 32'd1);
        check("sb_wb3_pend", 32'(rd_pending), 32'b10);
        check("sb_wb3_data", rd[31:0], 32'h33);

        we = 2'b10; wa[9:5] = 5'd9; wd[63:32] = 32'h99;
        issue_valid = 1'b1; issue_wa = 5'd9;
        tick();
        idle();
        #1;
        check("sb_setwins", 32'(pend_count), 32'd1);
        check("sb_setw_pend", 32'(rd_pending), 32'b10);
        check("sb_setw_data", rd[63:32], 32'h99);

        issue_valid = 1'b1; issue_wa = 5'd0;
        tick();
        idle();
        ra = {5'd9, 5'd0};
        #1;
        check("sb_issue0", 32'(pend_count), 32'd1);
        check("sb_pend0", 32'(rd_pending), 32'b10);

        // Bypass versus stored contents on a pending register
        we = 2'b01; wa[4:0] = 5'd4; wd[31:0] = 32'h44;
        tick();
        idle();
        issue_valid = 1'b1; issue_wa = 5'd4;
        tick();
        idle();
        ra = {5'd9, 5'd4};
        we = 2'b01; wa[4:0] = 5'd4; wd[31:0] = 32'hA5A5A5A5;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_rd", rd[31:0], 32'hA5A5A5A5);
        check("byp_pend", 32'(rd_pending), 32'b10);
`else
        check("byp_rd", rd[31:0], 32'h44);
        check("byp_pend", 32'(rd_pending), 32'b11);
`endif
        check("byp_cnt_pre", 32'(pend_count), 32'd2);
        tick();
        idle();
        #1;
        check("byp_rd_after", rd[31:0], 32'hA5A5A5A5);
        check("byp_cnt_post", 32'(pend_count), 32'd1);

        // Mid-stream reset discards pending state and contents
        for (int k = 5; k <= 7; k++) begin
            issue_valid = 1'b1; issue_wa = 5'(k);
            tick();
        end
        idle();
        #1;
        check("mid_cnt4", 32'(pend_count), 32'd4);
        reset_n = 1'b0;
        we = 2'b01; wa[4:0] = 5'd12; wd[31:0] = 32'hBAD;
        issue_valid = 1'b1; issue_wa = 5'd12;
        tick();
        reset_n = 1'b1;
        idle();
        #1;
        check("mid_cnt0", 32'(pend_count), 32'd0);
        for (int a = 0; a < DEPTH; a += 2) begin
            ra = {5'(a + 1), 5'(a)};
            #1;
            check("mid_rd0", rd[31:0], 32'h0);
            check("mid_rd1", rd[63:32], 32'h0);
            check("mid_pend", 32'(rd_pending), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
